// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode constants, forward-select codes and scoreboard types for the pipeline controller.
// No logic of its own; the forward-select helper is purely combinational.
// No flow control here; consumers decide when slots advance.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_EX   = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } ctrl_state_t;

    // rd is stored as x0 for instructions that do not write, so x0 never matches.
    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       is_load;
        logic       is_mem;
    } sb_slot_t;

    localparam sb_slot_t SLOT_EMPTY = '0;

    function automatic logic [1:0] fwd_sel(input sb_slot_t ex, input sb_slot_t mem,
                                           input logic used, input logic [4:0] rs);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (used && rs != 5'd0) begin
            if (ex.vld && !ex.is_load && ex.rd == rs)
                sel = FWD_EX;
            else if (mem.vld && mem.rd == rs)
                sel = FWD_MEM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/inst_decode_regs.sv
// Register-usage decode of the ID-stage instruction (sources used, destination written, memory class).
// Purely combinational, 0-cycle latency.
// No flow control; output follows inst every cycle.
module inst_decode_regs
    import rv32i_pkg::*;
(
    input  logic [31:0] inst,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        writes_rd,
    output logic        is_load,
    output logic        is_mem,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign rd          = inst[11:7];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign unused_bits = ^{inst[31:25], inst[14:12]};

    assign uses_rs1  = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    assign uses_rs2  = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
    assign writes_rd = !(opcode == OPC_STORE || opcode == OPC_BRANCH) && (rd != 5'd0);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_mem    = (opcode == OPC_LOAD) || (opcode == OPC_STORE);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage RV32I core with a 2-slot (EX, MEM) destination scoreboard.
// Enables, bubbles, flushes and forward selects are combinational (0-cycle); state and counters update on clk.
// A MEM-stage access without dmem_ready freezes every pipeline register until memory completes.
module pipeline_ctrl
    import rv32i_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int FLUSH_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_inst,
    input  logic             id_valid,
    input  logic             ex_taken,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_fl,
    output logic             id_ex_bub,
    output logic [1:0]       fwd_rs1,
    output logic [1:0]       fwd_rs2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0]       SQUASH_INIT = (FLUSH_CYC > 0) ? 2'(FLUSH_CYC - 1) : 2'd0;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic        uses_rs1, uses_rs2, writes_rd, is_load, is_mem;
    logic [4:0]  rs1, rs2, rd;

    sb_slot_t    id_slot, ex_slot, mem_slot;
    ctrl_state_t state, state_nxt;
    logic [1:0]  squash_cnt, squash_nxt;
    logic        mem_hold, ex_hit_rs1, ex_hit_rs2, load_use;

    inst_decode_regs u_decode (
        .inst      (id_inst),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd),
        .is_load   (is_load),
        .is_mem    (is_mem),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd)
    );

    always_comb begin
        id_slot         = SLOT_EMPTY;
        id_slot.vld     = id_valid;
        id_slot.rd      = writes_rd ? rd : 5'd0;
        id_slot.is_load = is_load;
        id_slot.is_mem  = is_mem;
    end

    assign mem_hold   = mem_slot.vld && mem_slot.is_mem && !dmem_ready;
    assign ex_hit_rs1 = uses_rs1 && (rs1 != 5'd0) && (ex_slot.rd == rs1);
    assign ex_hit_rs2 = uses_rs2 && (rs2 != 5'd0) && (ex_slot.rd == rs2);
    assign load_use   = ex_slot.vld && ex_slot.is_load && id_valid && (ex_hit_rs1 || ex_hit_rs2);

    assign fwd_rs1 = fwd_sel(ex_slot, mem_slot, uses_rs1, rs1);
    assign fwd_rs2 = fwd_sel(ex_slot, mem_slot, uses_rs2, rs2);

    // MEM_WAIT shares RUN's rules: its slots are frozen, so mem_hold reduces to !dmem_ready.
    always_comb begin
        state_nxt  = state;
        squash_nxt = squash_cnt;
        pc_en      = 1'b1;
        if_id_en   = 1'b1;
        id_ex_en   = 1'b1;
        ex_mem_en  = 1'b1;
        if_id_fl   = 1'b0;
        id_ex_bub  = 1'b0;
        if (rst_n) begin
            case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    state_nxt = ST_RUN;
                    if (mem_hold) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        state_nxt = ST_MEM_WAIT;
                    end else if (ex_taken) begin
                        if_id_fl  = 1'b1;
                        id_ex_bub = 1'b1;
                        if (FLUSH_CYC > 0) begin
                            state_nxt  = ST_FLUSH;
                            squash_nxt = SQUASH_INIT;
                        end
                    end else if (load_use) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_bub = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if_id_fl = 1'b1;
                    if (ex_taken)
                        squash_nxt = SQUASH_INIT;
                    else if (squash_cnt == 2'd0)
                        state_nxt = ST_RUN;
                    else
                        squash_nxt = squash_cnt - 2'd1;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            squash_cnt <= 2'd0;
            ex_slot    <= SLOT_EMPTY;
            mem_slot   <= SLOT_EMPTY;
        end else begin
            state      <= state_nxt;
            squash_cnt <= squash_nxt;
            if (ex_mem_en) begin
                mem_slot <= ex_slot;
                ex_slot  <= (id_valid && !id_ex_bub && !if_id_fl) ? id_slot : SLOT_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_fl && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
